// File: rtl/pwm_sample_scheduler.sv
// Sample-rate sequencer for a counter-compare PWM DAC: buffers source samples and
// releases one per PWM period, with priming, underrun ramp-to-midscale and soft mute.
//
// state   | meaning
// --------+------------------------------------------------------------------
// prime   | waiting for a full FIFO before starting playback; d held
// play    | one sample popped into d at every period end
// starved | FIFO ran dry; d ramps toward midscale until FIFO is half full
// mute    | d ramps toward midscale; FIFO drained one entry per period
module pwm_sample_scheduler #(
    parameter int signalwidth = 16,
    parameter int pwmwidth    = 6,
    parameter int depth_log2  = 2,
    parameter int ramp_step   = 256
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [signalwidth-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   mute,
    input  logic                   clear_underrun,
    output logic [signalwidth-1:0] d,
    output logic                   frame_strobe,
    output logic                   underrun,
    output logic [depth_log2:0]    level
);

    localparam int depth = 1 << depth_log2;
    localparam int ptr_w = (depth_log2 > 0) ? depth_log2 : 1;
    localparam int lvl_w = depth_log2 + 1;
    localparam logic [lvl_w-1:0] lvl_full   = lvl_w'(depth);
    localparam logic [lvl_w-1:0] lvl_resume = lvl_w'((depth == 1) ? 1 : depth / 2);
    localparam logic [signalwidth-1:0] mid  = {1'b1, {(signalwidth-1){1'b0}}};
    localparam logic [signalwidth-1:0] step = signalwidth'(ramp_step);

    typedef enum logic [1:0] {
        st_prime,
        st_play,
        st_starved,
        st_mute
    } state_t;

    state_t                   state;
    logic [pwmwidth-1:0]      cnt;
    logic [signalwidth-1:0]   mem [depth];
    logic [ptr_w-1:0]         wr_ptr;
    logic [ptr_w-1:0]         rd_ptr;
    logic [signalwidth-1:0]   head;
    logic [signalwidth-1:0]   ramp_d;
    logic                     push;
    logic                     load;
    logic                     discard;
    logic                     pop;

    function automatic logic [ptr_w-1:0] ptr_next(input logic [ptr_w-1:0] p);
        return (p == ptr_w'(depth - 1)) ? '0 : p + ptr_w'(1);
    endfunction

    assign frame_strobe = (cnt == '1);
    assign in_ready     = (level != lvl_full);
    assign push         = in_valid && in_ready;
    assign head         = mem[rd_ptr];
    assign pop          = load || discard;

    // One step toward midscale, snapping to mid when within a step so it never overshoots.
    always_comb begin
        ramp_d = mid;
        if (d > mid) begin
            if ((d - mid) > step) begin
                ramp_d = d - step;
            end
        end else if (d < mid) begin
            if ((mid - d) > step) begin
                ramp_d = d + step;
            end
        end
    end

    // Pops happen only at period end; a pending mute change takes priority over them.
    always_comb begin
        load    = 1'b0;
        discard = 1'b0;
        if (frame_strobe) begin
            case (state)
                st_prime:   load    = !mute && (level == lvl_full);
                st_play:    load    = !mute && (level != '0);
                st_starved: load    = !mute && (level >= lvl_resume);
                st_mute:    discard = mute && (level != '0);
                default:    load    = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= st_prime;
            cnt      <= '0;
            d        <= mid;
            underrun <= 1'b0;
            level    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            cnt <= cnt + pwmwidth'(1);

            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (push && !pop) begin
                level <= level + lvl_w'(1);
            end else if (pop && !push) begin
                level <= level - lvl_w'(1);
            end

            if (clear_underrun) begin
                underrun <= 1'b0;
            end

            if (mute && state != st_mute) begin
                state <= st_mute;
            end else begin
                case (state)
                    st_prime: begin
                        if (load) begin
                            d     <= head;
                            state <= st_play;
                        end
                    end
                    st_play: begin
                        if (load) begin
                            d <= head;
                        end else if (frame_strobe && level == '0) begin
                            underrun <= 1'b1;
                            state    <= st_starved;
                        end
                    end
                    st_starved: begin
                        if (load) begin
                            d     <= head;
                            state <= st_play;
                        end else if (frame_strobe) begin
                            d <= ramp_d;
                        end
                    end
                    st_mute: begin
                        if (!mute) begin
                            state <= st_prime;
                        end else if (frame_strobe) begin
                            d <= ramp_d;
                        end
                    end
                    default: state <= st_prime;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_sample_scheduler.sv
// Bench for pwm_sample_scheduler: directed scenarios plus randomized traffic, with a
// queue-based reference model feeding a per-period scoreboard.
module tb_pwm_sample_scheduler;

    localparam int DEPTH  = 4;
    localparam int PERIOD = 64;
    localparam int MID    = 32768;
    localparam int STEP   = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mute;
    logic        clear_underrun;
    logic [15:0] d;
    logic        frame_strobe;
    logic        underrun;
    logic [2:0]  level;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int d;
        int lvl;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    // reference model state
    int m_q[$];
    int m_d = MID;
    int m_und = 0;
    int m_cnt = 0;
    int m_mode = 0;   // 0 prime, 1 play, 2 starved, 3 mute
    bit started = 1'b0;
    bit prev_fs = 1'b0;
    bit sb_strobe;
    bit sb_push;

    pwm_sample_scheduler dut (
        .clk            (clk),
        .reset          (reset),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .mute           (mute),
        .clear_underrun (clear_underrun),
        .d              (d),
        .frame_strobe   (frame_strobe),
        .underrun       (underrun),
        .level          (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    function automatic int model_ramp(input int v);
        int diff;
        diff = v - MID;
        if (diff > STEP) return v - STEP;
        if (diff < -STEP) return v + STEP;
        return MID;
    endfunction

    // Behavioural model: tracks the buffer as a queue and the period by counting clocks.
    always @(posedge clk) begin
        sb_strobe = (m_cnt == PERIOD - 1);
        if (reset) begin
            m_q.delete();
            m_d     = MID;
            m_und   = 0;
            m_cnt   = 0;
            m_mode  = 0;
            started = 1'b1;
        end else if (started) begin
            sb_push = in_valid && (m_q.size() < DEPTH);
            if (clear_underrun) m_und = 0;
            if (mute && m_mode != 3) begin
                m_mode = 3;
            end else if (!mute && m_mode == 3) begin
                m_mode = 0;
            end else if (sb_strobe) begin
                if (m_mode == 0) begin
                    if (m_q.size() == DEPTH) begin
                        m_d = m_q.pop_front();
                        m_mode = 1;
                    end
                end else if (m_mode == 1) begin
                    if (m_q.size() > 0) begin
                        m_d = m_q.pop_front();
                    end else begin
                        m_und  = 1;
                        m_mode = 2;
                    end
                end else if (m_mode == 2) begin
                    if (m_q.size() >= DEPTH / 2) begin
                        m_d = m_q.pop_front();
                        m_mode = 1;
                    end else begin
                        m_d = model_ramp(m_d);
                    end
                end else begin
                    m_d = model_ramp(m_d);
                    if (m_q.size() > 0) void'(m_q.pop_front());
                end
            end
            if (sb_push) m_q.push_back(int'(in_data));
            m_cnt = (m_cnt + 1) % PERIOD;
        end
        if (sb_strobe && started) begin
            e.d   = m_d;
            e.lvl = m_q.size();
            exp_q.push_back(e);
        end
    end

    // Monitor: per-cycle handshake/flag checks, per-period scoreboard on d.
    always @(negedge clk) begin
        if (started) begin
            check("frame_strobe", 32'(frame_strobe), 32'(m_cnt == PERIOD - 1));
            check("level", 32'(level), 32'(m_q.size()));
            check("in_ready", 32'(in_ready), 32'(m_q.size() != DEPTH));
            check("underrun", 32'(underrun), 32'(m_und));
            if (prev_fs) begin
                if (exp_q.size() == 0) begin
                    fail_now("scoreboard_empty");
                end else begin
                    e = exp_q.pop_front();
                    check("sb_d", 32'(d), 32'(e.d));
                    check("sb_level", 32'(level), 32'(e.lvl));
                end
            end else begin
                check("d_hold", 32'(d), 32'(m_d));
            end
            prev_fs = frame_strobe;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send(input logic [15:0] v);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = v;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #2;
        end
        in_valid = 1'b0;
        if (!ok) fail_now("send_timeout");
    endtask

    // Returns 2 time units after the edge that closes the next strobe cycle.
    task automatic wait_strobe();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < PERIOD + 8 && !seen; i++) begin
            @(negedge clk);
            seen = frame_strobe;
        end
        if (!seen) fail_now("strobe_timeout");
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        in_valid       = 1'b0;
        in_data        = '0;
        mute           = 1'b0;
        clear_underrun = 1'b0;
        tick(3);
        reset = 1'b0;

        check("rst_d", 32'(d), 32'h8000);
        check("rst_level", 32'(level), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_strobe", 32'(frame_strobe), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);

        // priming and playback
        for (int i = 1; i <= 4; i++) send(16'(i * 16'h1000));
        check("full_level", 32'(level), 32'd4);
        check("full_ready", 32'(in_ready), 32'd0);
        wait_strobe();
        check("play_d0", 32'(d), 32'h1000);
        check("play_lvl0", 32'(level), 32'd3);
        wait_strobe();
        check("play_d1", 32'(d), 32'h2000);
        wait_strobe();
        check("play_d2", 32'(d), 32'h3000);
        wait_strobe();
        check("play_d3", 32'(d), 32'h4000);

        // underrun and ramp
        wait_strobe();
        check("starve_und", 32'(underrun), 32'd1);
        check("starve_hold", 32'(d), 32'h4000);
        wait_strobe();
        check("ramp_1", 32'(d), 32'h4100);
        wait_strobe();
        check("ramp_2", 32'(d), 32'h4200);

        // resume from starved at half full
        send(16'hA000);
        send(16'hB000);
        wait_strobe();
        check("resume_d", 32'(d), 32'hA000);
        check("resume_und", 32'(underrun), 32'd1);
        clear_underrun = 1'b1;
        tick(1);
        clear_underrun = 1'b0;
        check("clear_und", 32'(underrun), 32'd0);
        wait_strobe();
        check("resume_d2", 32'(d), 32'hB000);
        wait_strobe();
        check("restarve_und", 32'(underrun), 32'd1);
        wait_strobe();
        check("ramp_down", 32'(d), 32'hAF00);

        // soft mute from play
        pulse_reset();
        repeat (4) send(16'hFF00);
        wait_strobe();
        check("mute_start", 32'(d), 32'hFF00);
        mute = 1'b1;
        wait_strobe();
        check("mute_r1", 32'(d), 32'hFE00);
        check("mute_l1", 32'(level), 32'd2);
        wait_strobe();
        check("mute_r2", 32'(d), 32'hFD00);
        wait_strobe();
        wait_strobe();
        check("mute_r4", 32'(d), 32'hFB00);
        check("mute_l4", 32'(level), 32'd0);
        mute = 1'b0;
        tick(2);
        wait_strobe();
        check("unmute_hold", 32'(d), 32'hFB00);

        // reset mid-play
        pulse_reset();
        repeat (4) send(16'h1234);
        wait_strobe();
        check("pre_rst_lvl", 32'(level), 32'd3);
        tick(10);
        pulse_reset();
        check("mid_rst_d", 32'(d), 32'h8000);
        check("mid_rst_lvl", 32'(level), 32'd0);
        check("mid_rst_und", 32'(underrun), 32'd0);
        check("mid_rst_fs", 32'(frame_strobe), 32'd0);
        check("mid_rst_rdy", 32'(in_ready), 32'd1);

        // full FIFO with valid held across a strobe
        repeat (4) send(16'h5555);
        in_valid = 1'b1;
        in_data  = 16'h6666;
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < PERIOD + 8 && !seen; i++) begin
                @(negedge clk);
                seen = frame_strobe;
            end
            if (!seen) fail_now("full_strobe_timeout");
            check("full_hold_lvl", 32'(level), 32'd4);
            check("full_hold_rdy", 32'(in_ready), 32'd0);
            @(posedge clk);
            #2;
            check("after_pop_lvl", 32'(level), 32'd3);
            check("after_pop_rdy", 32'(in_ready), 32'd1);
            @(posedge clk);
            #2;
            check("refill_lvl", 32'(level), 32'd4);
        end
        in_valid = 1'b0;

        // randomized traffic at several source rates
        for (int phase = 0; phase < 4; phase++) begin
            int rate;
            rate = (phase == 0) ? 8 : (phase == 1) ? 60 : (phase == 2) ? 100 : 4;
            for (int c = 0; c < 3000; c++) begin
                in_valid       = ($urandom_range(0, rate - 1) == 0);
                in_data        = 16'($urandom_range(0, 65535));
                clear_underrun = ($urandom_range(0, 49) == 0);
                if ($urandom_range(0, 399) == 0) mute = !mute;
                reset = ($urandom_range(0, 2999) == 0);
                tick(1);
            end
        end
        in_valid       = 1'b0;
        clear_underrun = 1'b0;
        reset          = 1'b0;
        mute           = 1'b0;
        tick(3);
        @(negedge clk);
        #1;
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
